i2c_bus_condition_detector: RTL and testbench

- Next-generation I2C bus condition detector for the slave/monitor datapath.
- Synchronises and glitch-filters raw SCL/SDA.
- Detects START, repeated START and STOP.
- Tracks bus busy/free state, with a bus-free timeout for recovery from a lost STOP.
- Feeds the byte shifter and address matcher with single-cycle event pulses and clean line copies.

---
 rtl/i2c_bus_condition_detector.sv | 162 ++++++++++++++++
 tb/tb_i2c_bus_condition_detector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_condition_detector.sv
// rtl/i2c_bus_condition_detector.sv - I2C SCL/SDA sync+filter with START/rSTART/STOP/timeout decode
// Optional START/STOP event counters under I2C_COND_STATS_EN.
module i2c_bus_condition_detector #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_CYCLES  = 3,
  parameter int FILT_W       = 4,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int TO_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        scl,
  input  logic        sda,
`ifdef I2C_COND_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] start_cnt,
  output logic [15:0] stop_cnt,
`endif
  output logic        scl_f,
  output logic        sda_f,
  output logic        start,
  output logic        rstart,
  output logic        stop,
  output logic        timeout,
  output logic        bus_busy
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Line index 1 is SCL, index 0 is SDA throughout.
  logic [1:0]                  w_raw;
  logic [1:0][SYNC_STAGES-1:0] r_sync;
  logic [1:0][FILT_W-1:0]      r_fcnt;
  logic [1:0]                  r_filt;
  logic [1:0]                  r_prev;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic            r_start, r_rstart, r_stop, r_timeout;
  logic            w_start_nxt, w_rstart_nxt, w_stop_nxt, w_timeout_nxt;
  logic            w_start_cond, w_stop_cond, w_edge;

  assign w_raw = {scl, sda};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_fcnt <= '0;
      r_filt <= '1;
      r_prev <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
        r_prev[i] <= r_filt[i];
        if (r_sync[i][SYNC_STAGES-1] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_W'(FILT_CYCLES - 1)) begin
          r_filt[i] <= r_sync[i][SYNC_STAGES-1];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  // A simultaneous SCL edge makes scl_p differ from scl_f, masking both conditions.
  assign w_start_cond = r_prev[1] & r_filt[1] &  r_prev[0] & ~r_filt[0];
  assign w_stop_cond  = r_prev[1] & r_filt[1] & ~r_prev[0] &  r_filt[0];
  assign w_edge       = |(r_prev ^ r_filt);

  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = '0;
    w_start_nxt   = 1'b0;
    w_rstart_nxt  = 1'b0;
    w_stop_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_cond) begin
            w_state_nxt = ST_BUSY;
            w_start_nxt = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_edge)
            w_to_cnt_nxt = '0;
          else if (r_filt == 2'b11 && r_to_cnt != {TO_W{1'b1}})
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          else
            w_to_cnt_nxt = r_to_cnt;
          if (w_stop_cond) begin
            w_state_nxt  = ST_IDLE;
            w_stop_nxt   = 1'b1;
            w_to_cnt_nxt = '0;
          end else if (w_start_cond) begin
            w_rstart_nxt = 1'b1;
          end else if (w_to_cnt_nxt >= TO_W'(IDLE_TIMEOUT)) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
            w_to_cnt_nxt  = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_to_cnt  <= '0;
      r_start   <= 1'b0;
      r_rstart  <= 1'b0;
      r_stop    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_start   <= w_start_nxt;
      r_rstart  <= w_rstart_nxt;
      r_stop    <= w_stop_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign scl_f    = r_filt[1];
  assign sda_f    = r_filt[0];
  assign start    = r_start;
  assign rstart   = r_rstart;
  assign stop     = r_stop;
  assign timeout  = r_timeout;
  assign bus_busy = (r_state == ST_BUSY);

`ifdef I2C_COND_STATS_EN
  logic [15:0] r_start_cnt;
  logic [15:0] r_stop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_start_cnt <= '0;
      r_stop_cnt  <= '0;
    end else begin
      if ((r_start || r_rstart) && r_start_cnt != 16'hFFFF)
        r_start_cnt <= r_start_cnt + 16'd1;
      if (r_stop && r_stop_cnt != 16'hFFFF)
        r_stop_cnt <= r_stop_cnt + 16'd1;
    end
  end

  assign start_cnt = r_start_cnt;
  assign stop_cnt  = r_stop_cnt;
`endif

endmodule

// File: tb/tb_i2c_bus_condition_detector.sv
// tb/tb_i2c_bus_condition_detector.sv - self-checking bench for i2c_bus_condition_detector
module tb_i2c_bus_condition_detector;
  localparam int SYNC    = 2;
  localparam int FILT    = 3;
  localparam int IDLE_TO = 20;
  localparam int LAT     = SYNC + FILT + 1;

  logic clk, rst_n, enable, scl, sda;
  logic scl_f, sda_f, start, rstart, stop, timeout, bus_busy;
`ifdef I2C_COND_STATS_EN
  logic        stat_clr;
  logic [15:0] start_cnt, stop_cnt;
  logic [15:0] m_scnt, m_pcnt;
`endif

  i2c_bus_condition_detector #(
    .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .FILT_W(4), .IDLE_TIMEOUT(IDLE_TO), .TO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scl(scl), .sda(sda),
`ifdef I2C_COND_STATS_EN
    .stat_clr(stat_clr), .start_cnt(start_cnt), .stop_cnt(stop_cnt),
`endif
    .scl_f(scl_f), .sda_f(sda_f), .start(start), .rstart(rstart), .stop(stop),
    .timeout(timeout), .bus_busy(bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start = 0, n_rstart = 0, n_stop = 0, n_to = 0, n_sda_low = 0;

  // Reference model: raw samples ripple through a queue, the filter flips when the
  // last FILT synchronised samples all disagree with the filtered value.
  logic [1:0] m_raw_q[$];
  logic [1:0] m_seen_q[$];
  logic [1:0] m_filt, m_prev;
  bit         m_busy, m_start, m_rstart, m_stop, m_to;
  int         m_run;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw_q.delete();
    m_seen_q.delete();
    repeat (SYNC) m_raw_q.push_back(2'b11);
    repeat (FILT) m_seen_q.push_back(2'b11);
    m_filt = 2'b11;
    m_prev = 2'b11;
    m_busy = 0; m_run = 0;
    {m_start, m_rstart, m_stop, m_to} = 4'b0;
  endtask

  task automatic model_step();
    logic [1:0] so;
    bit sc, pc, ed, alld;
    if (!rst_n) begin
      model_reset();
`ifdef I2C_COND_STATS_EN
      m_scnt = 0; m_pcnt = 0;
`endif
      return;
    end
`ifdef I2C_COND_STATS_EN
    if (stat_clr) begin
      m_scnt = 0; m_pcnt = 0;
    end else begin
      if ((m_start || m_rstart) && m_scnt != 16'hFFFF) m_scnt++;
      if (m_stop && m_pcnt != 16'hFFFF) m_pcnt++;
    end
`endif
    sc = m_prev[1] & m_filt[1] &  m_prev[0] & ~m_filt[0];
    pc = m_prev[1] & m_filt[1] & ~m_prev[0] &  m_filt[0];
    ed = (m_prev != m_filt);
    {m_start, m_rstart, m_stop, m_to} = 4'b0;
    if (!enable) begin
      m_busy = 0; m_run = 0;
    end else if (!m_busy) begin
      m_run = 0;
      if (sc) begin m_busy = 1; m_start = 1; end
    end else begin
      if (ed) m_run = 0;
      else if (m_filt == 2'b11) m_run++;
      if (pc) begin m_busy = 0; m_stop = 1; m_run = 0; end
      else if (sc) m_rstart = 1;
      else if (m_run >= IDLE_TO) begin m_busy = 0; m_to = 1; m_run = 0; end
    end
    so = m_raw_q.pop_front();
    m_raw_q.push_back({scl, sda});
    void'(m_seen_q.pop_front());
    m_seen_q.push_back(so);
    m_prev = m_filt;
    for (int b = 0; b < 2; b++) begin
      alld = 1;
      foreach (m_seen_q[k]) if (m_seen_q[k][b] == m_filt[b]) alld = 0;
      if (alld) m_filt[b] = ~m_filt[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("outs", {scl_f, sda_f, start, rstart, stop, timeout, bus_busy},
             {m_filt[1], m_filt[0], m_start, m_rstart, m_stop, m_to, m_busy});
`ifdef I2C_COND_STATS_EN
    check_eq("start_cnt_model", start_cnt, m_scnt);
    check_eq("stop_cnt_model", stop_cnt, m_pcnt);
`endif
    n_start   += start;
    n_rstart  += rstart;
    n_stop    += stop;
    n_to      += timeout;
    n_sda_low += !sda_f;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pulse(input int which, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if ((which == 0 && start) || (which == 1 && rstart) ||
          (which == 2 && stop) || (which == 3 && timeout)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_start();
    sda = 0; hold(10);
  endtask

  task automatic do_rstart();
    scl = 0; hold(6); sda = 1; hold(6); scl = 1; hold(6); sda = 0; hold(10);
  endtask

  task automatic do_stop();
    scl = 0; hold(6); sda = 0; hold(6); scl = 1; hold(6); sda = 1; hold(10);
  endtask

  initial begin
    int lat, s0, r0, p0;
    rst_n = 0; enable = 1; scl = 1; sda = 1;
`ifdef I2C_COND_STATS_EN
    stat_clr = 0;
`endif
    hold(3);
    check_eq("reset_outs", {scl_f, sda_f, start, rstart, stop, timeout, bus_busy}, 7'b1100000);
    rst_n = 1;
    hold(10);

    sda = 0;
    wait_pulse(0, lat);
    check_eq("start_latency", lat, LAT);
    tick();
    check_eq("busy_after_start", bus_busy, 1);
    hold(5);

    s0 = n_start; r0 = n_rstart;
    do_rstart();
    check_eq("rstart_count", n_rstart - r0, 1);
    check_eq("rstart_no_start", n_start - s0, 0);
    check_eq("rstart_busy", bus_busy, 1);

    scl = 0; hold(6); scl = 1; hold(6);
    sda = 1;
    wait_pulse(2, lat);
    check_eq("stop_latency", lat, LAT);
    tick();
    check_eq("busy_after_stop", bus_busy, 0);

    p0 = n_stop;
    do_stop();
    check_eq("idle_stop_ignored", n_stop - p0, 0);

    s0 = n_start; n_sda_low = 0;
    sda = 0; hold(2); sda = 1; hold(12);
    check_eq("glitch2_sdaf", n_sda_low, 0);
    check_eq("glitch2_start", n_start - s0, 0);
    sda = 0; hold(3); sda = 1; hold(12);
    check_eq("glitch3_start", n_start - s0, 1);

    do_start();
    scl = 0; hold(6); sda = 1; hold(6);
    scl = 1;
    wait_pulse(3, lat);
    check_eq("timeout_latency", lat, LAT + IDLE_TO);
    check_eq("timeout_busy", bus_busy, 0);
    hold(5);

    do_start();
    check_eq("busy_before_reset", bus_busy, 1);
    rst_n = 0; scl = 1; sda = 1;
    tick();
    check_eq("reset_mid", {scl_f, sda_f, start, rstart, stop, timeout, bus_busy}, 7'b1100000);
    rst_n = 1;
    p0 = n_stop;
    hold(20);
    check_eq("reset_no_stop", n_stop - p0, 0);
    check_eq("reset_idle", bus_busy, 0);

    s0 = n_start; p0 = n_stop;
    enable = 0; do_start(); enable = 1; hold(10);
    check_eq("disabled_start_lost", n_start - s0, 0);
    check_eq("disabled_busy", bus_busy, 0);
    sda = 1; hold(10);
    check_eq("disabled_no_stop", n_stop - p0, 0);
    do_start();
    enable = 0; tick();
    check_eq("disable_forces_idle", bus_busy, 0);
    enable = 1; sda = 1; hold(10);

`ifdef I2C_COND_STATS_EN
    stat_clr = 1; tick(); stat_clr = 0;
    do_start(); do_rstart(); do_stop(); do_start(); do_stop(); do_start();
    hold(3);
    check_eq("stats_start_cnt", start_cnt, 4);
    check_eq("stats_stop_cnt", stop_cnt, 2);
    stat_clr = 1; tick(); stat_clr = 0;
    check_eq("stats_clr_start", start_cnt, 0);
    check_eq("stats_clr_stop", stop_cnt, 0);
    do_stop();
    enable = 0; do_start(); enable = 1; hold(3);
    check_eq("stats_disabled", start_cnt, 0);
    sda = 1; hold(10);
`endif

    for (int seg = 0; seg < 350; seg++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst_n = 0; tick(); rst_n = 1;
      end else if (r < 6) begin
        enable = ~enable;
      end
`ifdef I2C_COND_STATS_EN
      stat_clr = ($urandom_range(0, 49) == 0);
`endif
      scl = 1'($urandom_range(0, 1));
      sda = 1'($urandom_range(0, 1));
      hold($urandom_range(1, 9));
    end
    enable = 1; scl = 1; sda = 1;
`ifdef I2C_COND_STATS_EN
    stat_clr = 0;
`endif
    hold(10);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
